conv_requant: RTL
=================

# conv_requant

Requantization stage directly downstream of the 3x3/1x1 convolution core. It accepts the 32-bit per-lane accumulator beats that the core emits on its output handshake, and fetches per-output-channel bias/scale/shift from the core's bias RAM via `Bias_Addrb`. For each lane it computes `sat8(round((acc + bias) * scale >> shift))` in a stallable pipeline and presents 8-bit activations to the write-back stage with valid/ready.

## Interface
Parameters:
- COMPUTE_CHANNEL_OUT_NUM, 8, output channels per beat
- PICTURE_NUM, 1, pictures per beat
- WIDTH_DATA_ADD, 32, accumulator width per lane
- WIDTH_DATA, 8, output activation width
- WIDTH_BIAS_RAM_ADDRA, 7, bias RAM address width
- WIDTH_FEATURE_SIZE, 12, beat-counter width

Ports (clock and reset: one clock `clk`; reset `rst` is asynchronous and active-low):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- Start_Qu  in  1  one-cycle pulse that starts a layer; samples both REG inputs
- Pixels_Per_Group_REG  in  WIDTH_FEATURE_SIZE  beats per output-channel group, ≥1
- Group_Num_REG  in  WIDTH_BIAS_RAM_ADDRA  output-channel groups per layer, ≥1
- S_Data  in  PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM*WIDTH_DATA_ADD  accumulators; lane m, picture p at bits [(m*PICTURE_NUM+p)*32 +: 32]
- S_Valid  in  1  accumulator beat valid
- S_Ready  out  1  drives the core's M_ready
- Bias_Addrb  out  WIDTH_BIAS_RAM_ADDRA  bias RAM read address = current group
- Data_In_Bias / Data_In_Scale / Data_In_Shift  in  32*COMPUTE_CHANNEL_OUT_NUM each  channel m at [m*32 +: 32]; shift uses bits [5:0]
- M_Data  out  PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM*WIDTH_DATA  int8 results, same lane order
- M_Valid  out  1
- M_Ready  in  1
- Quant_Complete  out  1  one-cycle pulse after the last output is accepted
- Overflow_Err  out  1  sticky; a beat arrived while the skid buffer was full

## Operation
- FSM: IDLE → LOAD on Start_Qu. LOAD waits 2 cycles (bias RAM latency), then → RUN. In RUN, when the beat counter reaches Pixels_Per_Group_REG: increment group and Bias_Addrb, clear the beat counter, and go to LOAD. After the last beat of the last group → DRAIN. DRAIN stays until the pipeline and output register are empty, then pulses Quant_Complete and → IDLE.
- Start_Qu outside IDLE is ignored.
- Input skid FIFO, depth 2. The core's valid is one register late, so beats are accepted whenever S_Valid is high. S_Ready = (FIFO empty) && state==RUN. A write to a full FIFO drops the beat and sets Overflow_Err.
- Beats are counted when popped into the pipeline. Pops occur only in RUN, and never across a group boundary until LOAD completes.
- Per lane:
  - s1 = sat32(acc + bias), computed in 33 bits.
  - s2 = s1 * scale, signed 64-bit.
  - s3 = shift==0 ? s2 : (s2 + 2^(shift-1)) >>> shift. This is round-half-up.
  - out = sat to [-128,127].
- Pipeline enable ce = !M_Valid || M_Ready. All stages freeze when ce=0.

## Timing
- Reset values: S_Ready 0, M_Valid 0, M_Data 0, Bias_Addrb 0, Quant_Complete 0, Overflow_Err 0. FSM goes to IDLE, counters 0, FIFO empty.
- Latency: 4 cycles from FIFO pop to M_Valid when unstalled (add, multiply, round/shift, saturate/output reg). Throughput is 1 beat/cycle.
- M_Data is held stable while M_Valid && !M_Ready.
- Each group change costs a 2-cycle bubble; S_Ready is low during it.
- Bias_Addrb changes only on the cycle LOAD is entered. Parameters are sampled on the last LOAD cycle and held for the whole group.
- Reset asserted mid-layer aborts immediately. No Quant_Complete is produced.

## Configuration
- `CONV_REQUANT_RELU_EN` defined: s3 is clamped to [0,127], so negatives become 0.
- Not defined: signed saturation to [-128,127].

## Structure
- Shared package holds the FSM state encoding (IDLE, LOAD, RUN, DRAIN), the lane-extract width constants, and the sat32/sat8 functions.
- The per-lane arithmetic is one sub-module, `requant_lane`, instantiated COMPUTE_CHANNEL_OUT_NUM*PICTURE_NUM times. The FSM, skid FIFO and ce logic live in the top module.

## Test plan
- Basic: acc=1000, bias=24, scale=65536, shift=20 → lane out 64 (0x40), 4 cycles after pop.
- Rounding: acc=3, bias=0, scale=1, shift=1 → 2. acc=-3 under the same settings → -1.
- Saturation: acc=0x7FFFFFF0, bias=0x100, scale=1, shift=0 → 127. acc=-500, bias=0, scale=1, shift=0 → -128 (0x80) without the macro, 0 with `CONV_REQUANT_RELU_EN`.
- Groups: Pixels_Per_Group=4, Group_Num=2, 8 beats. Expect Bias_Addrb=0 for beats 0-3 and 1 for beats 4-7, S_Ready low for 2 cycles between groups, and a single Quant_Complete after the 8th output handshake.
- Backpressure: hold M_Ready low for 10 cycles mid-stream. M_Data must stay stable, no beats may be lost or duplicated, and Overflow_Err must stay 0 with a one-late upstream valid.
- Reset: assert rst low during RUN with 2 beats in flight. All outputs return to their reset values, and after a new Start_Qu the results are correct.

Source files
------------

// File: rtl/conv_requant_pkg.sv
// Shared FSM encoding, lane widths and saturation helpers for conv_requant.
// CONV_REQUANT_RELU_EN: when defined, sat8 clamps to [0,127] instead of [-128,127].
package conv_requant_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int ACC_W   = 32;
  localparam int PARAM_W = 32;
  localparam int SHIFT_W = 6;
  localparam int PROD_W  = 2 * ACC_W;
  localparam int OUT_W   = 8;

  // A 33-bit sum overflows 32 bits exactly when its top two bits differ.
  function automatic logic signed [ACC_W-1:0] sat32(input logic signed [ACC_W:0] v);
    if (v[ACC_W] != v[ACC_W-1])
      return v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return v[ACC_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] sat8(input logic signed [PROD_W-1:0] v);
`ifdef CONV_REQUANT_RELU_EN
    if (v < 64'sd0) return '0;
`else
    if (v < -64'sd128) return 8'h80;
`endif
    if (v > 64'sd127) return 8'h7F;
    return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One requantization lane: bias add, scale multiply, rounding shift, int8 saturate.
// Scale and shift travel with the data so a group change never retimes in-flight beats.
module requant_lane
  import conv_requant_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [ACC_W-1:0]   acc,
  input  logic [PARAM_W-1:0] bias,
  input  logic [PARAM_W-1:0] scale,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   q
);

  logic signed [ACC_W-1:0]   s1_reg;
  logic signed [PARAM_W-1:0] sc1_reg;
  logic [SHIFT_W-1:0]        sh1_reg;
  logic [SHIFT_W-1:0]        sh2_reg;
  logic signed [PROD_W-1:0]  s2_reg;
  logic signed [PROD_W-1:0]  s3_reg;
  logic [OUT_W-1:0]          q_reg;

  logic signed [ACC_W:0]     sum_next;
  logic signed [PROD_W-1:0]  s2_next;
  logic signed [PROD_W-1:0]  rnd_next;
  logic signed [PROD_W-1:0]  s3_next;

  always_comb begin
    sum_next = $signed({acc[ACC_W-1], acc}) + $signed({bias[PARAM_W-1], bias});
    s2_next  = $signed({{ACC_W{s1_reg[ACC_W-1]}}, s1_reg})
             * $signed({{(PROD_W-PARAM_W){sc1_reg[PARAM_W-1]}}, sc1_reg});
    // Half-LSB offset before the arithmetic shift gives round-half-up.
    rnd_next = (sh2_reg == '0) ? '0 : $signed(PROD_W'(1) << (sh2_reg - SHIFT_W'(1)));
    s3_next  = (s2_reg + rnd_next) >>> sh2_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_reg  <= '0;
      sc1_reg <= '0;
      sh1_reg <= '0;
      sh2_reg <= '0;
      s2_reg  <= '0;
      s3_reg  <= '0;
      q_reg   <= '0;
    end else if (ce) begin
      s1_reg  <= sat32(sum_next);
      sc1_reg <= scale;
      sh1_reg <= shift;
      s2_reg  <= s2_next;
      sh2_reg <= sh1_reg;
      s3_reg  <= s3_next;
      q_reg   <= sat8(s3_reg);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/conv_requant.sv
// Requantization stage behind the convolution core: skid FIFO, group FSM, lane array.
// Output clamp mode is selected by CONV_REQUANT_RELU_EN (see conv_requant_pkg).
module conv_requant
  import conv_requant_pkg::*;
#(
  parameter int COMPUTE_CHANNEL_OUT_NUM = 8,
  parameter int PICTURE_NUM             = 1,
  parameter int WIDTH_DATA_ADD          = 32,
  parameter int WIDTH_DATA              = 8,
  parameter int WIDTH_BIAS_RAM_ADDRA    = 7,
  parameter int WIDTH_FEATURE_SIZE      = 12
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   Start_Qu,
  input  logic [WIDTH_FEATURE_SIZE-1:0]                          Pixels_Per_Group_REG,
  input  logic [WIDTH_BIAS_RAM_ADDRA-1:0]                        Group_Num_REG,
  input  logic [PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM*WIDTH_DATA_ADD-1:0] S_Data,
  input  logic                                                   S_Valid,
  output logic                                                   S_Ready,
  output logic [WIDTH_BIAS_RAM_ADDRA-1:0]                        Bias_Addrb,
  input  logic [PARAM_W*COMPUTE_CHANNEL_OUT_NUM-1:0]             Data_In_Bias,
  input  logic [PARAM_W*COMPUTE_CHANNEL_OUT_NUM-1:0]             Data_In_Scale,
  input  logic [PARAM_W*COMPUTE_CHANNEL_OUT_NUM-1:0]             Data_In_Shift,
  output logic [PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM*WIDTH_DATA-1:0] M_Data,
  output logic                                                   M_Valid,
  input  logic                                                   M_Ready,
  output logic                                                   Quant_Complete,
  output logic                                                   Overflow_Err
);

  localparam int CO     = COMPUTE_CHANNEL_OUT_NUM;
  localparam int LANES  = CO * PICTURE_NUM;
  localparam int BEAT_W = LANES * WIDTH_DATA_ADD;
  localparam int WBA    = WIDTH_BIAS_RAM_ADDRA;
  localparam int WFS    = WIDTH_FEATURE_SIZE;

  state_e                 state_reg, state_next;
  logic                   load_cnt_reg;
  logic [WFS-1:0]         beat_cnt_reg, pix_reg;
  logic [WBA-1:0]         group_reg, grp_num_reg;
  logic [PARAM_W*CO-1:0]  bias_reg, scale_reg;
  logic [SHIFT_W*CO-1:0]  shift_reg, shift_bus;
  logic [CO-1:0]          unused_shift_bits;

  logic [BEAT_W-1:0]      fifo_mem [2];
  logic                   wr_ptr_reg, rd_ptr_reg;
  logic [1:0]             count_reg;
  logic                   overflow_reg;
  logic                   fifo_empty, fifo_full, push, pop;

  logic [2:0]             v_reg;
  logic                   m_valid_reg;
  logic                   ce, pipe_empty, last_beat, last_group;
  logic                   s_ready_c, quant_complete_c;

  assign ce         = !m_valid_reg || M_Ready;
  assign pipe_empty = !(|v_reg) && !m_valid_reg;
  assign fifo_empty = (count_reg == 2'd0);
  assign fifo_full  = (count_reg == 2'd2);
  assign last_beat  = ((beat_cnt_reg + WFS'(1)) == pix_reg);
  assign last_group = (group_reg == (grp_num_reg - WBA'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (Start_Qu) state_next = ST_LOAD;
      ST_LOAD:  if (load_cnt_reg) state_next = ST_RUN;
      ST_RUN:   if (pop && last_beat) state_next = last_group ? ST_DRAIN : ST_LOAD;
      ST_DRAIN: if (pipe_empty) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready_c        = (state_reg == ST_RUN) && fifo_empty;
    pop              = (state_reg == ST_RUN) && !fifo_empty && ce;
    quant_complete_c = (state_reg == ST_DRAIN) && pipe_empty;
  end

  // Upstream valid lags our ready by a cycle, so every valid beat is taken if there is room.
  assign push = S_Valid && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= S_Data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
      if (S_Valid && fifo_full && !pop) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt_reg <= 1'b0;
      beat_cnt_reg <= '0;
      pix_reg      <= '0;
      group_reg    <= '0;
      grp_num_reg  <= '0;
      bias_reg     <= '0;
      scale_reg    <= '0;
      shift_reg    <= '0;
    end else begin
      if (state_reg == ST_IDLE && Start_Qu) begin
        pix_reg      <= Pixels_Per_Group_REG;
        grp_num_reg  <= Group_Num_REG;
        group_reg    <= '0;
        beat_cnt_reg <= '0;
      end
      if (state_reg == ST_LOAD) begin
        load_cnt_reg <= ~load_cnt_reg;
        if (load_cnt_reg) begin
          bias_reg  <= Data_In_Bias;
          scale_reg <= Data_In_Scale;
          shift_reg <= shift_bus;
        end
      end
      if (pop) begin
        if (last_beat) begin
          beat_cnt_reg <= '0;
          if (!last_group) group_reg <= group_reg + WBA'(1);
        end else begin
          beat_cnt_reg <= beat_cnt_reg + WFS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_reg       <= '0;
      m_valid_reg <= 1'b0;
    end else if (ce) begin
      v_reg       <= {v_reg[1:0], pop};
      m_valid_reg <= v_reg[2];
    end
  end

  for (genvar gi = 0; gi < CO; gi++) begin : g_shift
    assign shift_bus[gi*SHIFT_W +: SHIFT_W] = Data_In_Shift[gi*PARAM_W +: SHIFT_W];
    assign unused_shift_bits[gi] = ^Data_In_Shift[gi*PARAM_W+SHIFT_W +: PARAM_W-SHIFT_W];
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int CH = gi / PICTURE_NUM;
    requant_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .ce    (ce),
      .acc   (fifo_mem[rd_ptr_reg][gi*WIDTH_DATA_ADD +: WIDTH_DATA_ADD]),
      .bias  (bias_reg[CH*PARAM_W +: PARAM_W]),
      .scale (scale_reg[CH*PARAM_W +: PARAM_W]),
      .shift (shift_reg[CH*SHIFT_W +: SHIFT_W]),
      .q     (M_Data[gi*WIDTH_DATA +: WIDTH_DATA])
    );
  end

  assign S_Ready        = s_ready_c;
  assign Bias_Addrb     = group_reg;
  assign M_Valid        = m_valid_reg;
  assign Quant_Complete = quant_complete_c;
  assign Overflow_Err   = overflow_reg;

endmodule
